// File: rtl/bcd_to_bin_if.sv
// Request/result bundle for the sequential BCD-to-binary converter.
// The requester drives start and the four digits; the converter drives the status and result.
interface bcd_to_bin_if #(
  parameter int unsigned OUT_W = 14
);
  logic             start;
  logic [3:0]       digit_1000;
  logic [3:0]       digit_100;
  logic [3:0]       digit_10;
  logic [3:0]       digit_1;
  logic             busy;
  logic             done;
  logic [OUT_W-1:0] bin_out;
  logic             err;

  modport master (
    output start, digit_1000, digit_100, digit_10, digit_1,
    input  busy, done, bin_out, err
  );

  modport slave (
    input  start, digit_1000, digit_100, digit_10, digit_1,
    output busy, done, bin_out, err
  );
endinterface

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter: four BCD digits folded MSD-first through
// one shared acc*10+digit step, one digit per clock, with start/busy/done/err handshake.
module bcd_to_bin_seq #(
  parameter int unsigned OUT_W = 14
) (
  input  logic        clk,
  input  logic        rst_n,
  bcd_to_bin_if.slave bus
);

  localparam int unsigned ACC_W = 14;
  localparam int unsigned DIG_W = 4;
  localparam int unsigned N_DIG = 4;
  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t                       state_q, state_n;
  logic [ACC_W-1:0]             acc_q, acc_n;
  logic [CNT_W-1:0]             cnt_q, cnt_n;
  logic [N_DIG-1:0][DIG_W-1:0]  dig_q, dig_n;
  logic                         busy_q, busy_n;
  logic                         done_q, done_n;
  logic                         err_q, err_n;
  logic [OUT_W-1:0]             bin_q, bin_n;

  logic [DIG_W-1:0]             cur_digit_c;
  logic [ACC_W-1:0]             acc_mac_c;
  logic                         bad_digit_c;

  // Index 0 is the thousands digit so cnt walks most-significant first.
  assign cur_digit_c = dig_q[cnt_q];
  assign acc_mac_c   = (acc_q << 3) + (acc_q << 1) + ACC_W'(cur_digit_c);

  assign bad_digit_c = (bus.digit_1000 > DIG_W'(9)) || (bus.digit_100 > DIG_W'(9)) ||
                       (bus.digit_10   > DIG_W'(9)) || (bus.digit_1   > DIG_W'(9));

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      dig_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      bin_q   <= '0;
    end else begin
      state_q <= state_n;
      acc_q   <= acc_n;
      cnt_q   <= cnt_n;
      dig_q   <= dig_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      err_q   <= err_n;
      bin_q   <= bin_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n = state_q;
    acc_n   = acc_q;
    cnt_n   = cnt_q;
    dig_n   = dig_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    err_n   = err_q;
    bin_n   = bin_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          dig_n   = {bus.digit_1, bus.digit_10, bus.digit_100, bus.digit_1000};
          acc_n   = '0;
          cnt_n   = '0;
          err_n   = 1'b0;
          busy_n  = 1'b1;
          state_n = bad_digit_c ? ERR : CONV;
        end
      end
      CONV: begin
        acc_n = acc_mac_c;
        cnt_n = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N_DIG - 1)) begin
          bin_n   = OUT_W'(acc_mac_c);
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      ERR: begin
        err_n   = 1'b1;
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.bin_out = bin_q;

endmodule

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
- Sequential BCD-to-binary converter; the inverse of the binary-to-BCD digit split used on the display path.
- Takes four BCD digits (thousands, hundreds, tens, ones), for example from a setpoint or threshold entry, and produces their binary value.
- Uses one shared multiply-by-10-and-add datapath over four cycles, with a start/busy/done handshake and an error flag for non-BCD digits.

Parameters:
- OUT_W, 14, binary output width. Must be >= 14 so 9999 fits; the upper bits read 0 when OUT_W > 14.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a conversion; sampled only in IDLE.
- digit_1000  input  4  thousands digit; captured on the accepting edge.
- digit_100  input  4  hundreds digit; captured on the accepting edge.
- digit_10  input  4  tens digit; captured on the accepting edge.
- digit_1  input  4  ones digit; captured on the accepting edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when a result (or error) is available.
- bin_out  output  OUT_W  registered binary result; holds its value until the next successful conversion.
- err  output  1  registered; 1 if the last accepted request had any digit > 9.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - busy=0, done=0, err=0, bin_out=0.
  - Internal accumulator, digit counter and captured digits all 0.
  - Takes effect immediately, including mid-conversion; no done pulse follows.
- States: IDLE, CONV, ERR.
- IDLE:
  - done deasserts unless set this cycle.
  - If start=1 at an edge: capture all four digits, clear acc and cnt, clear err.
  - If any captured digit > 9: go to ERR.
  - Otherwise go to CONV with busy=1.
- CONV:
  - Each edge: acc <= acc*10 + d[cnt], with digit order cnt=0..3 as 1000, 100, 10, 1.
  - acc*10 is formed as (acc<<3)+(acc<<1). acc is 14 bits wide internally; no overflow is possible because the maximum is 9999.
  - On the edge processing cnt=3: bin_out <= final value (zero-extended to OUT_W), done=1 for one cycle, busy=0, go to IDLE.
- ERR:
  - Next edge: err=1, done=1 for one cycle, busy=0, bin_out unchanged, go to IDLE.
  - busy is high during the single ERR cycle.
- Latency:
  - start sampled at edge E0; done is high in the cycle following edge E4 (4 cycles).
  - Error path: done high after edge E1.
- start while busy=1 is ignored; it is not queued.
- start high in the same cycle done is high is accepted, since the state is already IDLE. This gives back-to-back throughput of one result per 5 cycles.
- Input digits may change after the accepting edge without affecting the result.
- err stays high until the next accepted start clears it.
- done is never high for more than one consecutive cycle per request.

Test Plan:
- Reset, then start with digits 1,2,3,4 (thousands..ones) -> busy high 4 cycles; done pulses once on the 4th cycle after start; bin_out=1234 (0x4D2); err=0.
- Start with 9,9,9,9, then start with 0,0,0,0 -> bin_out=9999 (0x270F), then bin_out=0; each request gives exactly one done pulse.
- After bin_out=1234, start with 0,5,0xA,7 -> done 1 cycle after the accepting edge, err=1, bin_out stays 1234. A following valid start with 0,0,4,2 -> err=0, bin_out=42.
- Start with 5,6,7,8, pulse start again 2 cycles later with 1,1,1,1, and change the digit inputs during busy -> second start ignored; bin_out=5678; single done pulse.
- Assert rst_n=0 for 1 cycle in the middle of a conversion of 3,3,3,3 -> outputs zero immediately, no done afterwards. A new start of 0,0,0,7 -> bin_out=7.
- Hold start=1 continuously with 8,0,0,1 -> a new conversion is accepted in each done cycle; done pulses every 5 cycles; bin_out=8001 each time.
